// File: rtl/mem_access_pkg.sv
// Shared MIPS memory-stage definitions: access-size encodings, MEM/WB bubble value,
// and lane helpers for alignment, byte enables and load extension.
package mem_access_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_wr;
        logic misaligned;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Size 2'b10 is deliberately folded into the word case everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_SIZE_BYTE: is_misaligned = 1'b0;
            MEM_SIZE_HALF: is_misaligned = lane[0];
            default:       is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_SIZE_BYTE: byte_enables = 4'b0001 << lane;
            MEM_SIZE_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default:       byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic zero_ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_SIZE_BYTE: extend_load = zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
            MEM_SIZE_HALF: extend_load = zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
            default:       extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_data_memory.sv
// Word-organised data memory: byte-enable write on the rising edge, asynchronous read.
// Optional second read port for debug when MEM_DEBUG_PORT_EN is defined.
module mem_access_data_memory #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wr_be[l]) mem[addr][8*l +: 8] <= wr_data[8*l +: 8];
        end
    end

    assign rd_data = mem[addr];

`ifdef MEM_DEBUG_PORT_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage + MEM/WB register: 1-cycle latency, stall holds / flush bubbles, both block stores.
// MEM_DEBUG_PORT_EN adds a combinational word-indexed debug read port.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int IO_BUS_SIZE       = 32,
    parameter int MEM_SIZE_IN_WORDS = 256,
    parameter int REG_ADDR_SIZE     = 5,
    localparam int AW               = $clog2(MEM_SIZE_IN_WORDS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_mem_rd,
    input  logic                     i_mem_wr,
    input  logic [1:0]               i_mem_size,
    input  logic                     i_mem_unsigned,
    input  logic [IO_BUS_SIZE-1:0]   i_alu_result,
    input  logic [IO_BUS_SIZE-1:0]   i_store_data,
    input  logic                     i_reg_wr,
    input  logic [REG_ADDR_SIZE-1:0] i_wr_reg,
    input  logic                     i_mem_to_reg,
    output logic [IO_BUS_SIZE-1:0]   o_alu_result,
    output logic [IO_BUS_SIZE-1:0]   o_mem_result,
    output logic                     o_mem_to_reg,
    output logic                     o_reg_wr,
    output logic [REG_ADDR_SIZE-1:0] o_wr_reg,
    output logic                     o_misaligned
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]            i_debug_addr,
    output logic [IO_BUS_SIZE-1:0]   o_debug_data
`endif
);

    logic [1:0]             lane;
    logic [AW-1:0]          word_idx;
    logic                   misaligned;
    logic                   do_store;
    logic                   is_load;
    logic [3:0]             wr_be;
    logic [IO_BUS_SIZE-1:0] wr_data;
    logic [IO_BUS_SIZE-1:0] rd_word;
    logic [IO_BUS_SIZE-1:0] load_data;
    ctrl_t                  ctrl;

    assign lane     = i_alu_result[1:0];
    assign word_idx = i_alu_result[AW+1:2];

    // Only memory instructions can be misaligned; ALU ops carry arbitrary results.
    assign misaligned = (i_mem_rd | i_mem_wr) & is_misaligned(i_mem_size, lane);
    // Store wins over load when both are asserted; reset blocks any pending write.
    assign do_store   = i_reset & i_mem_wr & ~i_stall & ~i_flush & ~misaligned;
    assign is_load    = i_mem_rd & ~i_mem_wr & ~misaligned;
    assign wr_be      = do_store ? byte_enables(i_mem_size, lane) : 4'b0000;

    // Replicate narrow data across lanes so the byte enables pick the right copy.
    always_comb begin
        wr_data = i_store_data;
        case (i_mem_size)
            MEM_SIZE_BYTE: wr_data = {4{i_store_data[7:0]}};
            MEM_SIZE_HALF: wr_data = {2{i_store_data[15:0]}};
            default:       wr_data = i_store_data;
        endcase
    end

    mem_access_data_memory #(
        .DATA_W (IO_BUS_SIZE),
        .DEPTH  (MEM_SIZE_IN_WORDS)
    ) u_dmem (
        .clk      (i_clk),
        .wr_be    (wr_be),
        .addr     (word_idx),
        .wr_data  (wr_data),
        .rd_data  (rd_word)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .dbg_addr (i_debug_addr),
        .dbg_data (o_debug_data)
`endif
    );

    assign load_data = extend_load(rd_word, i_mem_size, lane, i_mem_unsigned);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_result <= '0;
            o_mem_result <= '0;
            o_wr_reg     <= '0;
            ctrl         <= CTRL_BUBBLE;
        end else if (i_flush) begin
            o_alu_result <= '0;
            o_mem_result <= '0;
            o_wr_reg     <= '0;
            ctrl         <= CTRL_BUBBLE;
        end else if (i_stall) begin
            ctrl.misaligned <= 1'b0;
        end else begin
            o_alu_result    <= i_alu_result;
            o_mem_result    <= is_load ? load_data : '0;
            o_wr_reg        <= i_wr_reg;
            ctrl.mem_to_reg <= i_mem_to_reg;
            ctrl.reg_wr     <= i_reg_wr & ~misaligned;
            ctrl.misaligned <= misaligned;
        end
    end

    assign o_mem_to_reg = ctrl.mem_to_reg;
    assign o_reg_wr     = ctrl.reg_wr;
    assign o_misaligned = ctrl.misaligned;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes hand-computed MEM/WB values,
// a monitor pops and compares one entry after each rising edge.
module tb_mem_access;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b11;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        m2r;
        logic        rw;
        logic [4:0]  wreg;
        logic        mis;
    } out_t;

    logic        i_clk, i_reset, i_stall, i_flush, i_mem_rd, i_mem_wr;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic [31:0] i_alu_result, i_store_data;
    logic        i_reg_wr;
    logic [4:0]  i_wr_reg;
    logic        i_mem_to_reg;
    logic [31:0] o_alu_result, o_mem_result;
    logic        o_mem_to_reg, o_reg_wr;
    logic [4:0]  o_wr_reg;
    logic        o_misaligned;
`ifdef MEM_DEBUG_PORT_EN
    logic [7:0]  i_debug_addr;
    logic [31:0] o_debug_data;
`endif

    mem_access dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_mem_rd       (i_mem_rd),
        .i_mem_wr       (i_mem_wr),
        .i_mem_size     (i_mem_size),
        .i_mem_unsigned (i_mem_unsigned),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .i_reg_wr       (i_reg_wr),
        .i_wr_reg       (i_wr_reg),
        .i_mem_to_reg   (i_mem_to_reg),
        .o_alu_result   (o_alu_result),
        .o_mem_result   (o_mem_result),
        .o_mem_to_reg   (o_mem_to_reg),
        .o_reg_wr       (o_reg_wr),
        .o_wr_reg       (o_wr_reg),
        .o_misaligned   (o_misaligned)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_debug_addr   (i_debug_addr),
        .o_debug_data   (o_debug_data)
`endif
    );

    int    tests  = 0;
    int    failed = 0;
    out_t  exp_q[$];
    string name_q[$];
    out_t  held = '0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic out_t dut_out();
        return '{o_alu_result, o_mem_result, o_mem_to_reg, o_reg_wr, o_wr_reg, o_misaligned};
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got alu=%h mem=%h m2r=%b rw=%b wreg=%0d mis=%b, want alu=%h mem=%h m2r=%b rw=%b wreg=%0d mis=%b",
                     name, got.alu, got.mem, got.m2r, got.rw, got.wreg, got.mis,
                     want.alu, want.mem, want.m2r, want.rw, want.wreg, want.mis);
        end
    endtask

    // Monitor: one expected MEM/WB value per captured stimulus cycle.
    initial begin
        out_t  e;
        string n;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, dut_out(), e);
            end
        end
    end

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_mem_rd = 0; i_mem_wr = 0; i_mem_size = SW;
        i_mem_unsigned = 0; i_alu_result = 0; i_store_data = 0; i_reg_wr = 0;
        i_wr_reg = 0; i_mem_to_reg = 0;
    endtask

    task automatic issue(input string name, input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic rw, input logic [4:0] wreg, input logic m2r,
                         input logic stall, input logic flush,
                         input logic [31:0] exp_mem, input logic exp_rw, input logic exp_mis);
        out_t e;
        @(negedge i_clk);
        i_mem_rd = rd; i_mem_wr = wr; i_mem_size = size; i_mem_unsigned = uns;
        i_alu_result = addr; i_store_data = sdata; i_reg_wr = rw; i_wr_reg = wreg;
        i_mem_to_reg = m2r; i_stall = stall; i_flush = flush;
        if (flush) e = '0;
        else if (stall) begin e = held; e.mis = 1'b0; end
        else e = '{addr, exp_mem, m2r, exp_rw, wreg, exp_mis};
        held = e;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic ld(input string name, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [4:0] wreg,
                      input logic [31:0] exp_mem, input logic exp_mis);
        issue(name, 1, 0, size, uns, addr, 32'h0, 1, wreg, 0, 0, 0, exp_mem, !exp_mis, exp_mis);
    endtask

    task automatic st(input string name, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_mis);
        issue(name, 0, 1, size, 0, addr, data, 0, 5'd0, 1, 0, 0, 32'h0, 0, exp_mis);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge i_clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            tests++; failed++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
            exp_q.delete(); name_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
`ifdef MEM_DEBUG_PORT_EN
        i_debug_addr = 8'd4;
`endif
        i_reset = 1'b1;
        #1 i_reset = 1'b0;
        #1 check("reset_state", dut_out(), '0);
        @(negedge i_clk);
        i_reset = 1'b1;

        st("st_w_10",          SW, 32'h10, 32'hDEADBEEF, 0);
        ld("ld_w_10",          SW, 0, 32'h10, 5'd3, 32'hDEADBEEF, 0);
`ifdef MEM_DEBUG_PORT_EN
        #1;
        tests++;
        if (o_debug_data !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL debug_port: got %h, want deadbeef", o_debug_data);
        end
`endif
        st("st_w_20",          SW, 32'h20, 32'hA1B2C3D4, 0);
        st("st_b_21",          SB, 32'h21, 32'h00000080, 0);
        ld("ld_b_21_signed",   SB, 0, 32'h21, 5'd4, 32'hFFFFFF80, 0);
        ld("ld_b_21_unsigned", SB, 1, 32'h21, 5'd4, 32'h00000080, 0);
        ld("ld_w_20_lanes",    SW, 0, 32'h20, 5'd5, 32'hA1B280D4, 0);
        st("st_w_10_b",        SW, 32'h10, 32'h12345678, 0);
        ld("ld_h_12_unsigned", SH, 1, 32'h12, 5'd6, 32'h00001234, 0);
        ld("ld_h_10_signed",   SH, 0, 32'h10, 5'd6, 32'h00005678, 0);
        ld("ld_b_13_signed",   SB, 0, 32'h13, 5'd6, 32'h00000012, 0);
        st("st_w_24",          SW, 32'h24, 32'h0000F0F0, 0);
        ld("ld_h_24_signed",   SH, 0, 32'h24, 5'd8, 32'hFFFFF0F0, 0);
        ld("ld_size10_word",   2'b10, 0, 32'h10, 5'd8, 32'h12345678, 0);
        ld("ld_h_13_misalign", SH, 1, 32'h13, 5'd6, 32'h0, 1);
        issue("stall_clears_mis", 0, 0, SW, 0, 32'h0, 32'h0, 0, 5'd0, 0, 1, 0, 32'h0, 0, 0);
        st("st_h_11_misalign", SH, 32'h11, 32'h0000FFFF, 1);
        st("st_w_12_misalign", SW, 32'h12, 32'hFFFFFFFF, 1);
        ld("ld_w_10_untouched", SW, 0, 32'h10, 5'd7, 32'h12345678, 0);
        st("st_w_30",          SW, 32'h30, 32'hCAFEF00D, 0);
        ld("ld_w_10_pre_stall", SW, 0, 32'h10, 5'd7, 32'h12345678, 0);
        issue("stall_store_hold", 0, 1, SW, 0, 32'h30, 32'h11111111, 0, 5'd0, 1, 1, 0, 32'h0, 0, 0);
        ld("ld_w_30_after_stall", SW, 0, 32'h30, 5'd2, 32'hCAFEF00D, 0);
        issue("flush_and_stall", 1, 0, SW, 0, 32'h30, 32'h0, 1, 5'd2, 0, 1, 1, 32'h0, 0, 0);
        ld("ld_w_30_refill",   SW, 0, 32'h30, 5'd2, 32'hCAFEF00D, 0);
        issue("flush_store",   0, 1, SW, 0, 32'h30, 32'h22222222, 0, 5'd0, 1, 0, 1, 32'h0, 0, 0);
        ld("ld_w_30_after_flush", SW, 0, 32'h30, 5'd2, 32'hCAFEF00D, 0);
        issue("rd_wr_both",    1, 1, SW, 0, 32'h40, 32'h55AA55AA, 1, 5'd9, 0, 0, 0, 32'h0, 1, 0);
        ld("ld_w_40",          SW, 0, 32'h40, 5'd9, 32'h55AA55AA, 0);
        st("st_w_400_alias",   SW, 32'h400, 32'h0BADF00D, 0);
        ld("ld_w_000_alias",   SW, 0, 32'h000, 5'd1, 32'h0BADF00D, 0);
        ld("ld_w_410_alias",   SW, 0, 32'h410, 5'd1, 32'h12345678, 0);
        drain();

        // Asynchronous reset between edges, with a store set up but never reaching an edge.
        @(negedge i_clk);
        i_mem_wr = 1; i_mem_size = SW; i_alu_result = 32'h50; i_store_data = 32'h99999999;
        #2 i_reset = 1'b0;
        #1 check("reset_midstream", dut_out(), '0);
        idle_inputs();
        #1 i_reset = 1'b1;

        ld("ld_w_10_post_reset", SW, 0, 32'h10, 5'd11, 32'h12345678, 0);
        ld("ld_w_20_post_reset", SW, 0, 32'h20, 5'd12, 32'hA1B280D4, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
